timer_sched: RTL
================

TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter NCH, default 4, number of timer channels (2..8).
REQ-002 Parameter W, default 32, width of the shared tick counter and of delays.
REQ-003 CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the CLOCK rising edge.
REQ-005 REQ_VALID  input  1  arm request valid.
REQ-006 REQ_READY  output  1  arm request accepted when REQ_VALID and REQ_READY are both high at an edge.
REQ-007 REQ_CH  input  ceil(log2(NCH))  channel to arm.
REQ-008 REQ_DELAY  input  W  delay in cycles.
REQ-009 REQ_PERIODIC  input  1  periodic-mode request; used only when TIMER_SCHED_PERIODIC_EN is defined.
REQ-010 CANCEL_VALID  input  1  cancel request; always accepted.
REQ-011 CANCEL_CH  input  ceil(log2(NCH))  channel to cancel.
REQ-012 EXP_VALID  output  1  expiry event presented.
REQ-013 EXP_CH  output  ceil(log2(NCH))  channel of the presented expiry.
REQ-014 EXP_ACK  input  1  consumer acknowledge; the event is consumed when EXP_VALID and EXP_ACK are both high at an edge.
REQ-015 TICK  output  W  shared free-running tick counter.
REQ-016 ARMED  output  NCH  per-channel armed flags.
REQ-017 OVERRUN  output  NCH  per-channel sticky overrun flags.

Function
REQ-018 TICK SHALL increment by 1 every cycle, wrapping from 2^W-1 to 0.
REQ-019 Per channel: flags ARMED and PENDING, a W-bit DEADLINE, a W-bit PERIOD register, and a periodic bit.
REQ-020 REQ_READY SHALL be high iff PENDING[REQ_CH] is low (combinational on REQ_CH).
REQ-021 On accept at tick T: DEADLINE = T + max(REQ_DELAY,1) mod 2^W, PERIOD = max(REQ_DELAY,1), ARMED set. Re-arming an ARMED channel restarts it.
REQ-022 Expiry: an ARMED channel whose DEADLINE equals TICK in cycle C SHALL have PENDING set at the end of C. One-shot: ARMED clears at the end of C. Net effect: an arm accepted at tick T with delay D expires in the cycle where TICK equals T+D.
REQ-023 Cancel SHALL clear ARMED of CANCEL_CH at that edge and SHALL NOT clear PENDING.
REQ-024 Arm and cancel of the same channel in the same cycle: the arm wins. Expiry and cancel in the same cycle: the expiry is recorded and ARMED is cleared.
REQ-025 Output FSM states: IDLE and HOLD.
  - IDLE: if any PENDING bit is set, select one round-robin starting at (last granted + 1) mod NCH, register EXP_CH, set EXP_VALID, go to HOLD.
  - HOLD: hold EXP_VALID and EXP_CH stable until EXP_ACK. On ACK, clear PENDING[EXP_CH], update the last-granted pointer, drop EXP_VALID, go to IDLE.
  - Minimum spacing between consecutive events is 2 cycles.
REQ-026 A PENDING bit SHALL be set no earlier than one cycle before EXP_VALID for that channel rises.
REQ-027 Wrap-around: a deadline computed across the TICK wrap SHALL fire at the correct post-wrap tick. Comparison is equality only.

Reset
REQ-028 While RST is high at an edge: TICK=0, ARMED=0, PENDING=0, OVERRUN=0, all DEADLINE and PERIOD registers=0, EXP_VALID=0, EXP_CH=0, last-granted pointer=NCH-1, FSM=IDLE.
REQ-029 Reset mid-operation SHALL discard all armed and pending timers. The first event after reset is not generated by any pre-reset request.
REQ-030 REQ_READY SHALL be high in the first cycle after reset.

Configuration
REQ-031 Macro TIMER_SCHED_PERIODIC_EN.
  - Defined: an arm with REQ_PERIODIC=1 sets the periodic bit. On expiry, the channel stays ARMED with DEADLINE += PERIOD. If an expiry occurs while PENDING is already set, OVERRUN for that channel is set; OVERRUN clears only on reset.
REQ-032 Macro TIMER_SCHED_PERIODIC_EN not defined: REQ_PERIODIC is ignored, all channels are one-shot, and OVERRUN is constant 0.

Verification
REQ-033 Reset, then arm ch0 with delay 5 accepted at TICK=3 -> PENDING[0] set in the cycle TICK=8; EXP_VALID=1, EXP_CH=0 from the next cycle; ARMED[0]=0.
REQ-034 Arm ch1 (delay 10) and ch2 (delay 10) in consecutive cycles, EXP_ACK held 0 for 20 cycles, then held 1 -> events presented for ch1 then ch2, each held stable until its ACK. REQ_READY is low for REQ_CH=1 while PENDING[1] is set.
REQ-035 After reset, advance TICK to 0xFFFFFFFE, arm ch3 with delay 4 -> expiry in the cycle TICK=2. Then arm ch0 delay 0 -> expiry one cycle later.
REQ-036 Arm ch2 delay 20, cancel ch2 at delay 10 -> no event. Same-cycle arm and cancel of ch2 with delay 3 -> event occurs.
REQ-037 With TIMER_SCHED_PERIODIC_EN defined: periodic ch1 with delay 4 and prompt ACK -> events every 4 cycles. With ACK withheld for 12 cycles -> OVERRUN[1]=1 and a single pending event. Without the macro -> exactly one event and OVERRUN=0.
REQ-038 Assert RST while ch0 and ch1 are armed and ch2 is pending -> zero events within 2^8 cycles after release; all outputs hold their reset values in the first cycle after release.

Source files
------------

// File: rtl/timer_sched_if.sv
// Arm/cancel request and expiry-event handshake bundle for timer_sched.
interface timer_sched_if #(
    parameter int NCH = 4,
    parameter int W   = 32
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_ch;
    logic [W-1:0]  req_delay;
    logic          req_periodic;
    logic          cancel_valid;
    logic [CW-1:0] cancel_ch;
    logic          exp_valid;
    logic [CW-1:0] exp_ch;
    logic          exp_ack;

    modport slave (
        input  req_valid, req_ch, req_delay, req_periodic, cancel_valid, cancel_ch, exp_ack,
        output req_ready, exp_valid, exp_ch
    );

    modport master (
        output req_valid, req_ch, req_delay, req_periodic, cancel_valid, cancel_ch, exp_ack,
        input  req_ready, exp_valid, exp_ch
    );
endinterface

// File: rtl/timer_sched.sv
// Multi-channel deadline timer with round-robin expiry presentation.
// Define TIMER_SCHED_PERIODIC_EN to enable periodic re-arm and overrun flags.
module timer_sched_ch #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] tick_i,
    input  logic         arm_i,
    input  logic [W-1:0] delay_i,
    input  logic         periodic_i,
    input  logic         cancel_i,
    input  logic         clr_i,
    output logic         armed_o,
    output logic         pend_o,
    output logic         pend_nxt_o,
    output logic         ovr_o
);
    logic         armed_q, armed_d, pend_q, pend_d;
    logic [W-1:0] dl_q, dl_d;
    logic         expire;

    assign expire = armed_q && (dl_q == tick_i);

`ifdef TIMER_SCHED_PERIODIC_EN
    logic         per_q, per_d, ovr_q, ovr_d;
    logic [W-1:0] prd_q, prd_d;
`else
    logic         unused_periodic;
    assign unused_periodic = periodic_i;
`endif

    // Priority on ARMED: arm > cancel > expiry; an expiry is always recorded.
    always_comb begin
        armed_d = armed_q;
        dl_d    = dl_q;
        pend_d  = pend_q;
        if (clr_i)  pend_d = 1'b0;
        if (expire) pend_d = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
        per_d = per_q;
        prd_d = prd_q;
        ovr_d = ovr_q | (expire & pend_q & ~clr_i);
        if (expire) begin
            armed_d = per_q;
            dl_d    = dl_q + prd_q;
        end
`else
        if (expire) armed_d = 1'b0;
`endif
        if (cancel_i) armed_d = 1'b0;
        if (arm_i) begin
            armed_d = 1'b1;
            dl_d    = tick_i + delay_i;
`ifdef TIMER_SCHED_PERIODIC_EN
            per_d   = periodic_i;
            prd_d   = delay_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            dl_q    <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
            per_q   <= 1'b0;
            prd_q   <= '0;
            ovr_q   <= 1'b0;
`endif
        end else begin
            armed_q <= armed_d;
            pend_q  <= pend_d;
            dl_q    <= dl_d;
`ifdef TIMER_SCHED_PERIODIC_EN
            per_q   <= per_d;
            prd_q   <= prd_d;
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign armed_o    = armed_q;
    assign pend_o     = pend_q;
    assign pend_nxt_o = pend_d;
`ifdef TIMER_SCHED_PERIODIC_EN
    assign ovr_o      = ovr_q;
`else
    assign ovr_o      = 1'b0;
`endif
endmodule

module timer_sched #(
    parameter int NCH = 4,
    parameter int W   = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    timer_sched_if.slave   bus_if,
    output logic [W-1:0]   tick_o,
    output logic [NCH-1:0] armed_o,
    output logic [NCH-1:0] overrun_o
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e         st_q, st_d;
    logic           vld_q, vld_d;
    logic [CW-1:0]  ch_q, ch_d, last_q, last_d, pick, cand;
    logic           hit, accept;
    logic [W-1:0]   tick_q, dly_eff;
    logic [NCH-1:0] arm, cxl, clr, pend, pend_nxt;

    assign accept              = bus_if.req_valid && bus_if.req_ready;
    assign dly_eff             = (bus_if.req_delay == '0) ? ONE : bus_if.req_delay;
    assign bus_if.req_ready    = ~pend[bus_if.req_ch];
    assign bus_if.exp_valid    = vld_q;
    assign bus_if.exp_ch       = ch_q;
    assign tick_o              = tick_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign arm[c] = accept && (bus_if.req_ch == CW'(c));
        assign cxl[c] = bus_if.cancel_valid && (bus_if.cancel_ch == CW'(c));
        assign clr[c] = (st_q == HOLD) && bus_if.exp_ack && (ch_q == CW'(c));

        timer_sched_ch #(.W(W)) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .tick_i     (tick_q),
            .arm_i      (arm[c]),
            .delay_i    (dly_eff),
            .periodic_i (bus_if.req_periodic),
            .cancel_i   (cxl[c]),
            .clr_i      (clr[c]),
            .armed_o    (armed_o[c]),
            .pend_o     (pend[c]),
            .pend_nxt_o (pend_nxt[c]),
            .ovr_o      (overrun_o[c])
        );
    end

    // Round-robin scan of next-cycle pending so an expiry is presented one cycle later.
    always_comb begin
        hit  = 1'b0;
        pick = last_q;
        cand = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = CW'((int'(last_q) + i) % NCH);
            if (!hit && pend_nxt[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        vld_d  = vld_q;
        ch_d   = ch_q;
        last_d = last_q;
        case (st_q)
            IDLE: if (hit) begin
                ch_d  = pick;
                vld_d = 1'b1;
                st_d  = HOLD;
            end
            HOLD: if (bus_if.exp_ack) begin
                vld_d  = 1'b0;
                last_d = ch_q;
                st_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= IDLE;
            vld_q  <= 1'b0;
            ch_q   <= '0;
            last_q <= CW'(NCH - 1);
            tick_q <= '0;
        end else begin
            st_q   <= st_d;
            vld_q  <= vld_d;
            ch_q   <= ch_d;
            last_q <= last_d;
            tick_q <= tick_q + ONE;
        end
    end
endmodule
